// File: rtl/main_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Holds the state enum, opcode classes, mux encodings and the registered control word.
package main_controller_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int NUM_CLASS  = 8;
    localparam int CLS_RALU   = 0;
    localparam int CLS_IALU   = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;

    typedef logic [NUM_CLASS-1:0] class_t;

    localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JAL    = 2'b10;
    localparam logic [1:0] PCSEL_JALR   = 2'b11;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_RAM = 2'b01;
    localparam logic [1:0] WBSEL_PC  = 2'b10;
    localparam logic [1:0] WBSEL_IMM = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef struct packed {
        logic       pcEn;
        logic [1:0] pcSelect;
        logic       regWrite;
        logic       aluSrc;
        logic       ramRdEn;
        logic       ramWrEn;
        logic       isByte;
        logic       isHalf;
        logic       isWord;
        logic [1:0] memToReg;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/main_controller_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
// master = controller side, slave = datapath / bench side.
interface main_controller_if #(
    parameter int DWIDTH = 32
) ();
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              pcEn;
    logic [1:0]        pcSelect;
    logic              regWrite;
    logic              aluSrc;
    logic              ramRdEn;
    logic              ramWrEn;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic [1:0]        memToReg;
    logic              halted;
    logic [DWIDTH-1:0] instrCount;

    modport master (
        input  opcode, funct3,
        output pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
               isByte, isHalf, isWord, memToReg, halted, instrCount
    );

    modport slave (
        output opcode, funct3,
        input  pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
               isByte, isHalf, isWord, memToReg, halted, instrCount
    );
endinterface

// File: rtl/main_controller_instr_class_decode.sv
// Maps an opcode to a one-hot instruction class plus an illegal flag.
// Purely combinational, no state.
module instr_class_decode
    import main_controller_pkg::*;
(
    input  logic [6:0] opcode,
    output class_t     instrClass,
    output logic       illegal
);
    always_comb begin
        instrClass = '0;
        case (opcode)
            OP_RALU:   instrClass[CLS_RALU]   = 1'b1;
            OP_IALU:   instrClass[CLS_IALU]   = 1'b1;
            OP_LOAD:   instrClass[CLS_LOAD]   = 1'b1;
            OP_STORE:  instrClass[CLS_STORE]  = 1'b1;
            OP_BRANCH: instrClass[CLS_BRANCH] = 1'b1;
            OP_JAL:    instrClass[CLS_JAL]    = 1'b1;
            OP_JALR:   instrClass[CLS_JALR]   = 1'b1;
            OP_LUI:    instrClass[CLS_LUI]    = 1'b1;
            default:   instrClass = '0;
        endcase
        illegal = ~|instrClass;
    end
endmodule

// File: rtl/main_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls.
// 3-5 cycles per instruction; all outputs registered, decoded from state + latched opcode/funct3.
// No backpressure. MAIN_CONTROLLER_HALT_ON_ILLEGAL_EN sends illegal encodings to HALT instead of NOP.
module main_controller
    import main_controller_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    main_controller_if.master bus
);
`ifdef MAIN_CONTROLLER_HALT_ON_ILLEGAL_EN
    localparam bit HaltOnIllegal = 1'b1;
`else
    localparam bit HaltOnIllegal = 1'b0;
`endif

    state_e            state;
    state_e            stateNext;
    logic [6:0]        opcodeQ;
    logic [2:0]        funct3Q;
    logic [6:0]        opcodeNext;
    logic [2:0]        funct3Next;
    logic [DWIDTH-1:0] instrCountQ;
    ctrl_t             ctrlQ;
    class_t            cls;
    logic              illegal;
    logic              unusedBits;

    function automatic state_e nextStateOf(state_e st, class_t c, logic ill, logic [1:0] size);
        state_e ns;
        logic   isMem;
        logic   badEnc;
        isMem  = c[CLS_LOAD] | c[CLS_STORE];
        badEnc = ill | (isMem & (size == SIZE_BAD));
        case (st)
            FETCH:  ns = DECODE;
            DECODE: ns = EXEC;
            EXEC: begin
                if (HaltOnIllegal && badEnc)    ns = HALT;
                else if (ill || c[CLS_BRANCH])  ns = FETCH;
                else if (isMem)                 ns = MEM;
                else                            ns = WB;
            end
            MEM:     ns = c[CLS_LOAD] ? WB : FETCH;
            WB:      ns = FETCH;
            HALT:    ns = HALT;
            default: ns = FETCH;
        endcase
        return ns;
    endfunction

    // Control word for the state being entered; size bits only while a RAM strobe is up.
    function automatic ctrl_t ctrlOf(state_e st, class_t c, logic ill, logic [1:0] size);
        ctrl_t o;
        o = '0;
        case (st)
            EXEC: begin
                o.aluSrc = c[CLS_IALU] | c[CLS_LOAD] | c[CLS_STORE] | c[CLS_JALR];
                if (c[CLS_BRANCH]) begin
                    o.pcEn     = 1'b1;
                    o.pcSelect = PCSEL_BRANCH;
                end else if (ill && !HaltOnIllegal) begin
                    o.pcEn = 1'b1;
                end
            end
            MEM: begin
                o.aluSrc  = 1'b1;
                o.ramRdEn = c[CLS_LOAD];
                o.ramWrEn = c[CLS_STORE];
                o.pcEn    = c[CLS_STORE];
            end
            WB: begin
                o.pcEn     = 1'b1;
                o.regWrite = 1'b1;
                o.aluSrc   = c[CLS_IALU] | c[CLS_LOAD] | c[CLS_JALR];
                o.ramRdEn  = c[CLS_LOAD];
                if (c[CLS_LOAD])                   o.memToReg = WBSEL_RAM;
                else if (c[CLS_JAL] | c[CLS_JALR]) o.memToReg = WBSEL_PC;
                else if (c[CLS_LUI])               o.memToReg = WBSEL_IMM;
                else                               o.memToReg = WBSEL_ALU;
                if (c[CLS_JAL])       o.pcSelect = PCSEL_JAL;
                else if (c[CLS_JALR]) o.pcSelect = PCSEL_JALR;
                else                  o.pcSelect = PCSEL_PLUS4;
            end
            HALT:    o.halted = 1'b1;
            default: o = '0;
        endcase
        if (o.ramRdEn || o.ramWrEn) begin
            o.isByte = (size == SIZE_BYTE);
            o.isHalf = (size == SIZE_HALF);
            o.isWord = (size == SIZE_WORD) || (size == SIZE_BAD);
        end
        return o;
    endfunction

    // The decoder sees the value that will sit in the latch next cycle, so the
    // registered control word for EXEC is ready the moment EXEC is entered.
    assign opcodeNext = (state == DECODE) ? bus.opcode : opcodeQ;
    assign funct3Next = (state == DECODE) ? bus.funct3 : funct3Q;

    instr_class_decode u_instrClassDecode (
        .opcode     (opcodeNext),
        .instrClass (cls),
        .illegal    (illegal)
    );

    assign stateNext = nextStateOf(state, cls, illegal, funct3Next[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            opcodeQ     <= '0;
            funct3Q     <= '0;
            instrCountQ <= '0;
            ctrlQ       <= '0;
        end else begin
            state   <= stateNext;
            opcodeQ <= opcodeNext;
            funct3Q <= funct3Next;
            ctrlQ   <= ctrlOf(stateNext, cls, illegal, funct3Next[1:0]);
            if (ctrlQ.pcEn) begin
                instrCountQ <= instrCountQ + DWIDTH'(1);
            end
        end
    end

    assign bus.pcEn       = ctrlQ.pcEn;
    assign bus.pcSelect   = ctrlQ.pcSelect;
    assign bus.regWrite   = ctrlQ.regWrite;
    assign bus.aluSrc     = ctrlQ.aluSrc;
    assign bus.ramRdEn    = ctrlQ.ramRdEn;
    assign bus.ramWrEn    = ctrlQ.ramWrEn;
    assign bus.isByte     = ctrlQ.isByte;
    assign bus.isHalf     = ctrlQ.isHalf;
    assign bus.isWord     = ctrlQ.isWord;
    assign bus.memToReg   = ctrlQ.memToReg;
    assign bus.instrCount = instrCountQ;
`ifdef MAIN_CONTROLLER_HALT_ON_ILLEGAL_EN
    assign bus.halted     = ctrlQ.halted;
`else
    assign bus.halted     = 1'b0;
`endif

    assign unusedBits = ^{funct3Next[2], ctrlQ.halted};

endmodule

// File: tb/tb_main_controller.sv
// Randomised scoreboard bench for main_controller: a per-cycle expected control word
// is queued from an instruction-level model and compared by an independent monitor.
module tb_main_controller;

`ifdef MAIN_CONTROLLER_HALT_ON_ILLEGAL_EN
    localparam bit HALT_MODE = 1'b1;
`else
    localparam bit HALT_MODE = 1'b0;
`endif

    localparam int K_RALU = 0, K_IALU = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4,
                   K_JAL = 5, K_JALR = 6, K_LUI = 7, K_ILL = 8;

    typedef struct packed {
        logic        pcEn;
        logic [1:0]  pcSelect;
        logic        regWrite;
        logic        aluSrc;
        logic        ramRdEn;
        logic        ramWrEn;
        logic        isByte;
        logic        isHalf;
        logic        isWord;
        logic [1:0]  memToReg;
        logic        halted;
        logic [31:0] count;
        logic [2:0]  countSmall;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    main_controller_if #(.DWIDTH(32)) bus ();
    main_controller_if #(.DWIDTH(3))  busSmall ();

    main_controller #(.DWIDTH(32)) dut      (.clk(clk), .reset(reset), .bus(bus.master));
    main_controller #(.DWIDTH(3))  dutSmall (.clk(clk), .reset(reset), .bus(busSmall.master));

    obs_t        expQ[$];
    string       tagQ[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] modelCount;

    function automatic int kindOf(logic [6:0] op);
        case (op)
            7'b0110011: return K_RALU;
            7'b0010011: return K_IALU;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic obs_t blank();
        obs_t v;
        v = '0;
        v.count      = modelCount;
        v.countSmall = modelCount[2:0];
        return v;
    endfunction

    task automatic setInputs(input logic [6:0] op, input logic [2:0] f3);
        bus.opcode      = op;
        bus.funct3      = f3;
        busSmall.opcode = op;
        busSmall.funct3 = f3;
    endtask

    task automatic pushOne(input obs_t v, input string tag);
        expQ.push_back(v);
        tagQ.push_back(tag);
    endtask

    // Expected outputs, cycle by cycle, for one instruction starting in its fetch cycle.
    task automatic pushInstr(input logic [6:0] op, input logic [2:0] f3, input string tag,
                             input int keep, output int n, output bit halts);
        obs_t v[5];
        int   k;
        bit   isMem, badEnc, a;
        k      = kindOf(op);
        isMem  = (k == K_LOAD) || (k == K_STORE);
        badEnc = (k == K_ILL) || (isMem && f3[1:0] == 2'b11);
        halts  = 1'b0;
        n      = 4;
        for (int i = 0; i < 5; i++) v[i] = blank();
        if (HALT_MODE && badEnc) begin
            n = 3; halts = 1'b1; v[2].aluSrc = isMem;
        end else begin
            case (k)
                K_ILL:    begin n = 3; v[2].pcEn = 1'b1; end
                K_BRANCH: begin n = 3; v[2].pcEn = 1'b1; v[2].pcSelect = 2'b01; end
                K_LOAD: begin
                    n = 5;
                    for (int i = 2; i < 5; i++) v[i].aluSrc = 1'b1;
                    for (int i = 3; i < 5; i++) begin
                        v[i].ramRdEn = 1'b1;
                        v[i].isByte  = (f3[1:0] == 2'b00);
                        v[i].isHalf  = (f3[1:0] == 2'b01);
                        v[i].isWord  = f3[1];
                    end
                    v[4].regWrite = 1'b1; v[4].memToReg = 2'b01; v[4].pcEn = 1'b1;
                end
                K_STORE: begin
                    v[2].aluSrc = 1'b1; v[3].aluSrc = 1'b1;
                    v[3].ramWrEn = 1'b1; v[3].pcEn = 1'b1;
                    v[3].isByte  = (f3[1:0] == 2'b00);
                    v[3].isHalf  = (f3[1:0] == 2'b01);
                    v[3].isWord  = f3[1];
                end
                default: begin
                    a = (k == K_IALU) || (k == K_JALR);
                    v[2].aluSrc = a; v[3].aluSrc = a;
                    v[3].pcEn = 1'b1; v[3].regWrite = 1'b1;
                    if (k == K_JAL || k == K_JALR) v[3].memToReg = 2'b10;
                    else if (k == K_LUI)           v[3].memToReg = 2'b11;
                    if (k == K_JAL)       v[3].pcSelect = 2'b10;
                    else if (k == K_JALR) v[3].pcSelect = 2'b11;
                end
            endcase
        end
        if (keep > 0) n = keep;
        for (int i = 0; i < n; i++) pushOne(v[i], tag);
        if (!halts && keep == 0) modelCount = modelCount + 32'd1;
    endtask

    // Called in a cycle whose expectation is already queued; leaves us in a fresh FETCH cycle.
    task automatic doReset(input int nHigh);
        reset      = 1'b1;
        modelCount = 32'd0;
        for (int i = 0; i < nHigh - 1; i++) pushOne(blank(), "reset");
        for (int i = 0; i < nHigh; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input string tag, input int keep);
        int n, waitCycles;
        bit halts;
        obs_t hv;
        pushInstr(op, f3, tag, keep, n, halts);
        if (halts) begin
            hv = blank();
            hv.halted = 1'b1;
            for (int i = 0; i < 21; i++) pushOne(hv, {tag, "-halt"});
        end
        setInputs(op, f3);
        waitCycles = (keep > 0) ? n - 1 : n;
        for (int c = 1; c <= waitCycles; c++) begin
            if (c == 3) setInputs(7'($urandom), 3'($urandom));
            @(posedge clk); #1;
        end
        if (halts) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
            end
            doReset(2 + int'($urandom_range(0, 2)));
        end else if (keep > 0) begin
            doReset(3);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        obs_t  a, e;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            a.pcEn       = bus.pcEn;
            a.pcSelect   = bus.pcSelect;
            a.regWrite   = bus.regWrite;
            a.aluSrc     = bus.aluSrc;
            a.ramRdEn    = bus.ramRdEn;
            a.ramWrEn    = bus.ramWrEn;
            a.isByte     = bus.isByte;
            a.isHalf     = bus.isHalf;
            a.isWord     = bus.isWord;
            a.memToReg   = bus.memToReg;
            a.halted     = bus.halted;
            a.count      = bus.instrCount;
            a.countSmall = busSmall.instrCount;
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: outputs got %h required %h (pcEn,pcSel,regWr,aluSrc,rd,wr,b,h,w,m2r,halt,cnt,cnt3)",
                         t, a, e);
            end
            checks++;
            if (bus.regWrite === 1'b1 && bus.ramWrEn === 1'b1) begin
                fails++;
                $display("FAIL %s: regWrite and ramWrEn both 1, required not both", t);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        int         r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        modelCount = 32'd0;
        reset = 1'b1;
        setInputs(7'd0, 3'd0);
        @(posedge clk); #1;
        pushOne(blank(), "reset-state");
        doReset(2);

        runInstr(7'b0000011, 3'b010, "lw-abort-in-mem", 4);
        runInstr(7'b0110011, 3'b000, "add", 0);
        runInstr(7'b0010011, 3'b000, "addi", 0);
        runInstr(7'b0000011, 3'b010, "lw", 0);
        runInstr(7'b0100011, 3'b000, "sb", 0);
        runInstr(7'b0000011, 3'b001, "lh", 0);
        runInstr(7'b0100011, 3'b101, "sh-funct3msb", 0);
        runInstr(7'b1100011, 3'b000, "beq", 0);
        runInstr(7'b1101111, 3'b000, "jal", 0);
        runInstr(7'b1100111, 3'b000, "jalr", 0);
        runInstr(7'b0110111, 3'b000, "lui", 0);
        runInstr(7'b0010111, 3'b000, "auipc-illegal", 0);
        runInstr(7'b0000011, 3'b011, "load-size11", 0);
        runInstr(7'b0100011, 3'b111, "store-size11", 0);
        for (int i = 0; i < 12; i++) runInstr(7'b1100011, 3'($urandom), "beq-wrap", 0);

        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 9) ? 7'($urandom) : ops[r];
            runInstr(op, 3'($urandom), "random", 0);
            if ($urandom_range(0, 24) == 0) begin
                pushOne(blank(), "random-reset");
                doReset(1 + int'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain: expectations left %0d, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/main_controller.md
# main_controller

Multi-cycle control unit that sequences the single-issue RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath control input: PC enable/select, register write, ALU source, RAM strobes and size, and writeback mux select. It also keeps a retired-instruction counter and a halt/illegal status for the bench and debug view.

## Interface
Parameters:
- `DWIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  instruction bits [6:0] from the instruction memory output.
- `funct3`  in  3  instruction bits [14:12].
- `pcEn`  out  1  PC update strobe; one cycle per retired instruction.
- `pcSelect`  out  2  next-PC source:
  - 00 = PC+4
  - 01 = conditional branch (datapath applies the comparator result)
  - 10 = PC+imm (JAL)
  - 11 = ALU result (JALR)
- `regWrite`  out  1  register file write enable.
- `aluSrc`  out  1  ALU operand B select: 1 = immediate, 0 = rs2.
- `ramRdEn`  out  1  RAM read enable.
- `ramWrEn`  out  1  RAM write enable.
- `isByte`, `isHalf`, `isWord`  out  1 each  RAM access size; one-hot while a RAM strobe is high, otherwise 0.
- `memToReg`  out  2  writeback source:
  - 00 = ALU
  - 01 = RAM
  - 10 = PC
  - 11 = immediate
- `halted`  out  1  controller is in HALT.
- `instrCount`  out  DWIDTH  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH waits one cycle for the registered instruction memory. It always goes to DECODE.
- DECODE latches `opcode` and `funct3` into internal registers. All later states decode only the latched copies. It then goes to EXEC.
- Supported instruction classes (latched opcode):
  - R-ALU 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - LUI 0110111
- Any other opcode is illegal.
- State paths per class:
  - R-ALU: FETCH, DECODE, EXEC, WB. WB drives `regWrite`=1, `memToReg`=00. `aluSrc`=0 in EXEC and WB.
  - I-ALU: same path as R-ALU, with `aluSrc`=1.
  - LOAD: FETCH, DECODE, EXEC, MEM, WB. `aluSrc`=1 from EXEC onward. MEM drives `ramRdEn`=1. WB drives `ramRdEn`=1, `regWrite`=1, `memToReg`=01.
  - STORE: FETCH, DECODE, EXEC, MEM. `aluSrc`=1. MEM drives `ramWrEn`=1 and `pcEn`=1.
  - BRANCH: FETCH, DECODE, EXEC. EXEC drives `aluSrc`=0, `pcSelect`=01, `pcEn`=1.
  - JAL: FETCH, DECODE, EXEC, WB. WB drives `regWrite`=1, `memToReg`=10, `pcSelect`=10.
  - JALR: same path as JAL. `aluSrc`=1. WB drives `memToReg`=10, `pcSelect`=11.
  - LUI: FETCH, DECODE, EXEC, WB. WB drives `regWrite`=1, `memToReg`=11.
- `pcEn` is asserted only in the final state of an instruction, together with that state's `pcSelect`. In every other state `pcSelect`=00.
- The state after a final state is FETCH.
- RAM size from latched `funct3[1:0]`: 00 byte, 01 half, 10 word. Sign/zero extension is done by RAM, not by this block.
- `instrCount` increments by 1 on every cycle with `pcEn`=1 and wraps modulo 2^DWIDTH.
- All outputs are Moore outputs: combinational from the state register and the latched opcode/funct3. No output depends combinationally on the `opcode`/`funct3` ports.

## Timing
- Cycles per instruction: BRANCH 3; R-ALU, I-ALU, JAL, JALR, LUI and STORE 4; LOAD 5.
- Reset:
  - State goes to FETCH; latched opcode/funct3 clear to 0; `instrCount` = 0.
  - All control outputs are 0 and `halted` = 0 in the cycle after reset is sampled high.
  - Reset mid-instruction aborts it with no `pcEn` and no `regWrite`.
  - Reset has priority over every transition, including exit from HALT.
- HALT drives all strobes 0 and holds `instrCount`. Only `reset` leaves HALT.
- There is never a cycle in which `regWrite` and `ramWrEn` are both 1.

## Configuration
- `MAIN_CONTROLLER_HALT_ON_ILLEGAL_EN` defined:
  - An illegal opcode, or LOAD/STORE with `funct3[1:0]`=11, goes from EXEC to HALT with no strobes asserted.
  - `pcEn` stays 0 and `instrCount` does not increment.
- Macro undefined:
  - Illegal encodings execute as a NOP: EXEC asserts `pcEn`=1 with `pcSelect`=00 and `instrCount` increments.
  - The size-11 case uses word size.
  - HALT is unreachable and `halted` is tied to 0.

## Structure
- Shared package `main_controller_pkg` holds:
  - the state enum;
  - the eight opcode constants;
  - the `pcSelect` and `memToReg` encodings;
  - the size encodings.
- One sub-module, `instr_class_decode`: combinational; maps the latched opcode to a one-hot class vector plus an illegal flag.
- The state register, latches, counter and output decode all live in `main_controller`.

## Test plan
- Reset held 3 cycles mid-LOAD (in MEM) → next cycle state FETCH, all outputs 0, `instrCount`=0, no `regWrite` pulse observed.
- ADD (0110011), then ADDI (0010011) → `pcEn` high at cycles 4 and 8. `regWrite`=1 with `memToReg`=00 only in WB. `aluSrc` is 0 for the ADD and 1 for the ADDI. `instrCount`=2.
- LW (funct3=010) → `ramRdEn` in cycles 4–5, `isWord`=1 only while `ramRdEn`=1, `memToReg`=01 with `regWrite` in cycle 5, `pcEn` in cycle 5. SB (funct3=000) → `ramWrEn`+`isByte` and `pcEn` in cycle 4, `regWrite` never 1.
- BEQ → `pcEn`=1 with `pcSelect`=01 in cycle 3. JAL → cycle 4 `regWrite`, `memToReg`=10, `pcSelect`=10. JALR → same cycle with `pcSelect`=11.
- Opcode 0010111 (AUIPC):
  - with macro defined → HALT at cycle 4, `halted`=1, `instrCount` unchanged, stays halted 20 cycles until reset;
  - without macro → `pcEn` with `pcSelect`=00 at cycle 3 and `instrCount`+1.
- Preload `instrCount`=2^32−1 via 2^32−1 forced retirements (or a force) → the next retirement wraps it to 0.
